rcservo_scheduler: RTL
======================

RCSERVO_SCHEDULER -- requirements
Module: rcservo_scheduler

Interface
REQ-001 Parameters SHALL be:
- CHANNELS, default 4: number of servo outputs.
- FRAME_TICKS, default 480000: frame period in clk cycles.
- CENTER_TICKS, default 72000: pulse width for position 0.
- SCALE_SHIFT, default 6: position-to-ticks right shift.
- MIN_TICKS, default 48000: minimum pulse width.
- MAX_TICKS, default 96000: maximum pulse width.
- GAP_TICKS, default 16: idle cycles between channel pulses.
REQ-002 Ports SHALL be (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run frames.
- wr_valid  in  1  position write request.
- wr_ready  out  1  write accepted when high together with wr_valid.
- wr_chan  in  clog2(CHANNELS)  target channel.
- wr_pos  in  32 signed  position command, in feedback counts.
- pwm  out  CHANNELS  servo pulse outputs.
- frame_start  out  1  one-cycle strobe at each frame begin.
- busy  out  1  high while a pulse or gap is in progress.
- active_chan  out  clog2(CHANNELS)  channel currently pulsing.

Function
REQ-003 The frame counter SHALL count 0..FRAME_TICKS-1 and wrap while enable=1 or while a frame is still in progress; otherwise it SHALL hold at 0.
REQ-004 When the counter is 0 and enable=1, the block SHALL assert frame_start for exactly one cycle and copy every pending position into the active positions (commit cycle).
REQ-005 wr_ready SHALL be 0 during the commit cycle and 1 in every other cycle.
REQ-006 An accepted write SHALL update only the pending position of wr_chan; a write with wr_chan >= CHANNELS SHALL be accepted and discarded.
REQ-007 Width SHALL be computed as CENTER_TICKS + (active_pos >>> SCALE_SHIFT):
- use an arithmetic shift;
- use at least 33-bit signed arithmetic;
- clamp the result to [MIN_TICKS, MAX_TICKS].
REQ-008 The FSM states SHALL be IDLE, COMMIT, PULSE, GAP and WAIT.
- IDLE -> COMMIT when enable=1 and the counter is 0.
- COMMIT -> PULSE, with channel 0 selected.
- PULSE -> GAP after exactly width(ch) cycles with pwm[ch]=1.
- GAP -> PULSE for the next channel after GAP_TICKS cycles.
- After the last channel, GAP -> WAIT.
- WAIT -> COMMIT at the counter wrap if enable=1; otherwise WAIT -> IDLE.
REQ-009 pwm SHALL be registered, at most one bit SHALL be high at any time, and pwm[0] SHALL first rise in the cycle after frame_start.
REQ-010 busy SHALL be 1 in PULSE and GAP only; active_chan SHALL hold the channel being pulsed and otherwise read 0.
REQ-011 Deasserting enable mid-frame SHALL NOT truncate the frame: the current frame completes, then the FSM returns to IDLE.
REQ-012 A write to channel k during the frame SHALL take effect only at the next commit, so in-frame widths never change.
REQ-013 Parameter constraint: CHANNELS*(MAX_TICKS+GAP_TICKS)+1 <= FRAME_TICKS; a simulation-time assertion SHALL flag violation.

Reset
REQ-014 While rst_n=0:
- pwm=0, frame_start=0, busy=0, active_chan=0, wr_ready=1;
- FSM=IDLE, frame counter=0;
- all pending and active positions=0.
REQ-015 Reset asserted mid-pulse SHALL force pwm low asynchronously; after release, the first frame starts only per REQ-004.

Structure
REQ-016 Package rcservo_pkg SHALL hold:
- the FSM state enum;
- the width-calculation/clamp function;
- default timing constants shared with rcservo.
REQ-017 One sub-module, rcservo_pulse_timer, SHALL implement the loadable down-counter used for both PULSE and GAP durations, with a done strobe.

Verification
All scenarios use CHANNELS=4, FRAME_TICKS=1000, CENTER_TICKS=150, SCALE_SHIFT=2, MIN_TICKS=100, MAX_TICKS=200, GAP_TICKS=10.
REQ-018 Write pos=40 to ch0, enable=1 -> at the next frame, pwm[0] is high for exactly 160 cycles starting one cycle after frame_start.
REQ-019 Write ch1=-1000 and ch2=1000 -> widths are clamped to 100 and 200; ch3 (never written) gives 150; channels pulse strictly in order with 10-cycle gaps.
REQ-020 Write ch0=400 at frame counter 50 of a running frame -> the current frame still shows the old width; the next frame shows 250, clamped to 200.
REQ-021 Assert wr_valid continuously -> wr_ready=0 only on the frame_start cycles; a write with wr_chan=5 (with CHANNELS widened to 5 bits of address) changes no output.
REQ-022 Drop enable during the ch1 pulse -> ch1..ch3 complete and the FSM reaches IDLE; pull rst_n low mid-pulse -> pwm=0 in the same cycle and all outputs take their reset values.

Source files
------------

// File: rtl/rcservo_pkg.sv
// rcservo_pkg: shared FSM states, default timing and pulse-width clamp for the servo scheduler
package rcservo_pkg;

    typedef enum logic [2:0] {IDLE, COMMIT, PULSE, GAP, WAIT} state_t;

    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_FRAME_TICKS  = 480000;
    localparam int DEF_CENTER_TICKS = 72000;
    localparam int DEF_SCALE_SHIFT  = 6;
    localparam int DEF_MIN_TICKS    = 48000;
    localparam int DEF_MAX_TICKS    = 96000;
    localparam int DEF_GAP_TICKS    = 16;

    // 34-bit signed sum so extreme positions cannot wrap before the clamp
    function automatic logic [31:0] pulse_width(
        input logic signed [31:0] pos,
        input int center,
        input int shift,
        input int lo,
        input int hi
    );
        logic signed [33:0] w;
        w = 34'(center) + 34'(pos >>> shift);
        return (w < 34'(lo)) ? 32'(lo) : (w > 34'(hi)) ? 32'(hi) : w[31:0];
    endfunction

endpackage

// File: rtl/rcservo_pulse_timer.sv
// rcservo_pulse_timer: loadable down-counter; done marks the last cycle of a loaded duration
module rcservo_pulse_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - W'(1);
    end

    assign done = cnt == W'(1);

endmodule

// File: rtl/rcservo_scheduler.sv
// rcservo_scheduler: frame-based RC servo pulse sequencer with positions double-buffered per frame
module rcservo_scheduler
    import rcservo_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
    parameter int CENTER_TICKS = DEF_CENTER_TICKS,
    parameter int SCALE_SHIFT  = DEF_SCALE_SHIFT,
    parameter int MIN_TICKS    = DEF_MIN_TICKS,
    parameter int MAX_TICKS    = DEF_MAX_TICKS,
    parameter int GAP_TICKS    = DEF_GAP_TICKS,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic signed [31:0]  wr_pos,
    output logic [CHANNELS-1:0] pwm,
    output logic                frame_start,
    output logic                busy,
    output logic [CW-1:0]       active_chan
);

    localparam int FW = $clog2(FRAME_TICKS);
    localparam int TW = $clog2((MAX_TICKS > GAP_TICKS ? MAX_TICKS : GAP_TICKS) + 1);
    localparam bit PARAMS_OK = CHANNELS * (MAX_TICKS + GAP_TICKS) + 1 <= FRAME_TICKS
                               && GAP_TICKS >= 1 && MIN_TICKS >= 1;

    state_t             state, nxt;
    logic [FW-1:0]      frame_cnt;
    logic [CW-1:0]      chan, nxt_chan;
    logic signed [31:0] pending [CHANNELS];
    logic signed [31:0] active  [CHANNELS];
    logic               load, done, wrap, last;
    logic [TW-1:0]      load_val;

    function automatic logic [TW-1:0] width_of(input logic signed [31:0] p);
        return TW'(pulse_width(p, CENTER_TICKS, SCALE_SHIFT, MIN_TICKS, MAX_TICKS));
    endfunction

    assign wrap        = frame_cnt == FW'(FRAME_TICKS - 1);
    assign last        = chan == CW'(CHANNELS - 1);
    assign frame_start = state == COMMIT;
    assign wr_ready    = state != COMMIT;
    assign busy        = state == PULSE || state == GAP;
    assign active_chan = state == PULSE ? chan : '0;

    rcservo_pulse_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (load_val),
        .done  (done)
    );

    always_comb begin
        nxt      = state;
        nxt_chan = chan;
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE:   if (enable && frame_cnt == '0) nxt = COMMIT;
            // pending is read here because active only takes it at the end of this cycle
            COMMIT: begin
                nxt      = PULSE;
                nxt_chan = '0;
                load     = 1'b1;
                load_val = width_of(pending[0]);
            end
            PULSE:  if (done) begin
                nxt      = GAP;
                load     = 1'b1;
                load_val = TW'(GAP_TICKS);
            end
            GAP:    if (done) begin
                if (last) nxt = wrap ? (enable ? COMMIT : IDLE) : WAIT;
                else begin
                    nxt      = PULSE;
                    nxt_chan = chan + CW'(1);
                    load     = 1'b1;
                    load_val = width_of(active[nxt_chan]);
                end
            end
            WAIT:   if (wrap) nxt = enable ? COMMIT : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            chan      <= '0;
            frame_cnt <= '0;
            pwm       <= '0;
        end else begin
            state     <= nxt;
            chan      <= nxt_chan;
            frame_cnt <= (state == IDLE || wrap) ? '0 : frame_cnt + FW'(1);
            pwm       <= nxt == PULSE ? CHANNELS'(1) << nxt_chan : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            if (wr_valid && wr_ready && int'(wr_chan) < CHANNELS) pending[wr_chan] <= wr_pos;
            if (state == COMMIT) active <= pending;
        end
    end

    assert property (@(posedge clk) PARAMS_OK)
        else $error("rcservo_scheduler: frame too short for CHANNELS*(MAX_TICKS+GAP_TICKS)+1");

endmodule
